// File: rtl/ddr_phy_pkg.sv
// ---------------------------------------------------------------------------
// ddr_phy_pkg
// Shared definitions for the DDR PHY read path.
//   DEF_BURST_LENGTH  default beats per READ burst
//   DEF_READ_LATENCY  default clk2x cycles from READ issue to first beat
//   SLOT_CNT_W        width of each in-flight slot's countdown
//   rd_cap_state_e    capture FSM states (IDLE / BURST)
//   preamble_ok()     true when the strobe pair shows a valid read preamble
// ---------------------------------------------------------------------------
package ddr_phy_pkg;

  localparam int DEF_BURST_LENGTH = 8;
  localparam int DEF_READ_LATENCY = 22;
  localparam int SLOT_CNT_W       = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_cap_state_e;

  // A read preamble drives the differential strobe low (t=0, c=1).
  function automatic logic preamble_ok(input logic dqs_t, input logic dqs_c);
    return (dqs_t == 1'b0) && (dqs_c == 1'b1);
  endfunction

endpackage

// File: rtl/phy_rd_slot_queue.sv
// ---------------------------------------------------------------------------
// phy_rd_slot_queue
// In-order queue of outstanding READs. Each slot carries a saturating
// down-counter loaded with LOAD_VAL on push; the head is "expired" once its
// counter reaches zero, which tells the capture FSM the burst is due.
// Ports:
//   clk2x           capture clock
//   rst             asynchronous active-low reset
//   i_push          request to enqueue a READ (ignored while full)
//   i_pop           dequeue the head slot
//   o_head_expired  head slot occupied and its countdown is zero
//   o_full          all DEPTH slots occupied
//   o_count         number of occupied slots
// ---------------------------------------------------------------------------
module phy_rd_slot_queue
  import ddr_phy_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LOAD_VAL = 21
) (
  input  logic                   clk2x,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  output logic                   o_head_expired,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [SLOT_CNT_W-1:0] LOAD     = SLOT_CNT_W'(LOAD_VAL);
  localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_occ [DEPTH];
  logic [SLOT_CNT_W-1:0] r_cnt [DEPTH];

  logic w_push;
  logic w_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full         = (r_count == CNT_W'(DEPTH));
  assign w_push         = i_push && !o_full;
  assign w_pop          = i_pop && r_occ[r_rd_ptr];
  assign o_head_expired = r_occ[r_rd_ptr] && (r_cnt[r_rd_ptr] == '0);
  assign o_count        = r_count;

  // Per-slot countdown. A freshly loaded slot does not decrement on the
  // load edge, so LOAD_VAL = latency-1 makes the head expire exactly
  // `latency` edges after the push edge.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk2x or negedge rst) begin
        if (!rst) begin
          r_occ[gi] <= 1'b0;
          r_cnt[gi] <= '0;
        end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
          r_occ[gi] <= 1'b1;
          r_cnt[gi] <= LOAD;
        end else if (w_pop && (r_rd_ptr == PTR_W'(gi))) begin
          r_occ[gi] <= 1'b0;
          r_cnt[gi] <= '0;
        end else if (r_occ[gi] && (r_cnt[gi] != '0)) begin
          r_cnt[gi] <= r_cnt[gi] - SLOT_CNT_W'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk2x or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/phy_read_capture_ctrl.sv
// ---------------------------------------------------------------------------
// phy_read_capture_ctrl
// Tracks outstanding READs and frames the returning DQ beats into bursts
// for the read-mode FIFO stage.
// Ports:
//   clk2x        capture clock
//   rst          asynchronous active-low reset
//   rdIssue      one-cycle pulse: READ command issued on the DRAM bus
//   dqs_t/dqs_c  differential read strobe (checked for the preamble)
//   inData       raw DQ bus
//   rdReady      a free in-flight slot exists
//   capValid     captured beat valid; capData carries the beat
//   burstFirst   first beat of a burst (qualified by capValid)
//   burstLast    last beat of a burst (qualified by capValid)
//   inflightCnt  queued READs not yet started
//   ovfErr       READ dropped because the queue was full (pulse)
//   lateErr      READ became due while the previous burst was running (pulse)
//   preambleErr  bad strobe preamble before a burst (pulse, first beat)
// ---------------------------------------------------------------------------
module phy_read_capture_ctrl
  import ddr_phy_pkg::*;
#(
  parameter int MEM_DATAWIDTH = 64,
  parameter int BURST_LENGTH  = DEF_BURST_LENGTH,
  parameter int READ_LATENCY  = DEF_READ_LATENCY,
  parameter int MAX_INFLIGHT  = 4
) (
  input  logic                            clk2x,
  input  logic                            rst,
  input  logic                            rdIssue,
  input  logic                            dqs_t,
  input  logic                            dqs_c,
  input  logic [MEM_DATAWIDTH-1:0]        inData,
  output logic                            rdReady,
  output logic                            capValid,
  output logic [MEM_DATAWIDTH-1:0]        capData,
  output logic                            burstFirst,
  output logic                            burstLast,
  output logic [$clog2(MAX_INFLIGHT):0]   inflightCnt,
  output logic                            ovfErr,
  output logic                            lateErr,
  output logic                            preambleErr
);

  localparam int BEAT_W = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LENGTH - 1);

  rd_cap_state_e             r_state;
  logic [BEAT_W-1:0]         r_beat;
  logic                      r_cap_valid;
  logic                      r_first;
  logic                      r_last;
  logic                      r_late_err;
  logic                      r_pre_err;
  logic                      r_late_seen;
  logic                      r_ovf_err;
  logic [MEM_DATAWIDTH-1:0]  r_cap_data;

  logic                            w_head_expired;
  logic                            w_full;
  logic                            w_push;
  logic                            w_start;
  logic [$clog2(MAX_INFLIGHT):0]   w_count;

  // Readiness looks only at the current occupancy, so a pop in the same
  // cycle never lets an issue into a full queue.
  assign w_push  = rdIssue && !w_full;

  // A burst may start from IDLE, or seamlessly right after the last beat.
  assign w_start = w_head_expired &&
                   ((r_state == ST_IDLE) || (r_beat == LAST_BEAT));

  phy_rd_slot_queue #(
    .DEPTH    (MAX_INFLIGHT),
    .LOAD_VAL (READ_LATENCY - 1)
  ) u_slot_queue (
    .clk2x          (clk2x),
    .rst            (rst),
    .i_push         (w_push),
    .i_pop          (w_start),
    .o_head_expired (w_head_expired),
    .o_full         (w_full),
    .o_count        (w_count)
  );

  always_ff @(posedge clk2x or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_cap_valid <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_late_err  <= 1'b0;
      r_pre_err   <= 1'b0;
      r_late_seen <= 1'b0;
    end else begin
      r_late_err <= 1'b0;
      r_pre_err  <= 1'b0;
      if (w_start) begin
        r_state     <= ST_BURST;
        r_beat      <= '0;
        r_cap_valid <= 1'b1;
        r_first     <= 1'b1;
        r_last      <= (BURST_LENGTH == 1);
        // dqs here is the strobe during the cycle before the first beat.
        r_pre_err   <= !preamble_ok(dqs_t, dqs_c);
        r_late_seen <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cap_valid <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
          end
          ST_BURST: begin
            if (r_beat == LAST_BEAT) begin
              r_state     <= ST_IDLE;
              r_beat      <= '0;
              r_cap_valid <= 1'b0;
              r_first     <= 1'b0;
              r_last      <= 1'b0;
            end else begin
              r_beat      <= r_beat + BEAT_W'(1);
              r_cap_valid <= 1'b1;
              r_first     <= 1'b0;
              r_last      <= ((r_beat + BEAT_W'(1)) == LAST_BEAT);
              // Head became due mid-burst: flag it once; it still runs
              // back-to-back after the current burst.
              if (w_head_expired && !r_late_seen) begin
                r_late_err  <= 1'b1;
                r_late_seen <= 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk2x or negedge rst) begin
    if (!rst) begin
      r_cap_data <= '0;
      r_ovf_err  <= 1'b0;
    end else begin
      r_cap_data <= inData;
      r_ovf_err  <= rdIssue && w_full;
    end
  end

  assign rdReady     = !w_full;
  assign capValid    = r_cap_valid;
  assign capData     = r_cap_data;
  assign burstFirst  = r_first;
  assign burstLast   = r_last;
  assign inflightCnt = w_count;
  assign ovfErr      = r_ovf_err;
  assign lateErr     = r_late_err;
  assign preambleErr = r_pre_err;

endmodule

// File: tb/tb_phy_read_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phy_read_capture_ctrl
// Directed and random READ traffic against a timeline model: each accepted
// READ is due at issue_edge + READ_LATENCY, bursts occupy BURST_LENGTH edges
// and the next one starts at max(due, previous start + BURST_LENGTH).
// Edge k is the k-th rising edge after reset release; inputs passed to
// step() are sampled at that edge, outputs are checked at the following
// falling edge. Data/strobe "of cycle k-1" are therefore passed for edge k.
// ---------------------------------------------------------------------------
module tb_phy_read_capture_ctrl;

  localparam int DW   = 64;
  localparam int BL   = 8;
  localparam int RL   = 22;
  localparam int MAXQ = 4;
  localparam int HN   = 512;

  logic                   clk2x = 1'b0;
  logic                   rst = 1'b1;
  logic                   rdIssue = 1'b0;
  logic                   dqs_t = 1'b0;
  logic                   dqs_c = 1'b1;
  logic [DW-1:0]          inData = '0;
  logic                   rdReady, capValid, burstFirst, burstLast;
  logic                   ovfErr, lateErr, preambleErr;
  logic [DW-1:0]          capData;
  logic [$clog2(MAXQ):0]  inflightCnt;

  phy_read_capture_ctrl #(
    .MEM_DATAWIDTH (DW),
    .BURST_LENGTH  (BL),
    .READ_LATENCY  (RL),
    .MAX_INFLIGHT  (MAXQ)
  ) dut (
    .clk2x       (clk2x),
    .rst         (rst),
    .rdIssue     (rdIssue),
    .dqs_t       (dqs_t),
    .dqs_c       (dqs_c),
    .inData      (inData),
    .rdReady     (rdReady),
    .capValid    (capValid),
    .capData     (capData),
    .burstFirst  (burstFirst),
    .burstLast   (burstLast),
    .inflightCnt (inflightCnt),
    .ovfErr      (ovfErr),
    .lateErr     (lateErr),
    .preambleErr (preambleErr)
  );

  always #5 clk2x = ~clk2x;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // timeline model state
  int due_q[$];
  bit head_late_seen;
  int burst_s;

  // expected outputs after the current edge
  logic          e_cv, e_first, e_last, e_late, e_ovf, e_pre, e_ready;
  logic [DW-1:0] e_data;
  int            e_cnt;

  // per-scenario stimulus and observed history, indexed by edge
  bit iss   [HN];
  bit baddq [HN];
  bit h_cv [HN], h_first [HN], h_last [HN], h_late [HN];
  bit h_ovf [HN], h_pre [HN], h_ready [HN];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    due_q.delete();
    head_late_seen = 1'b0;
    burst_s = -1000;
  endtask

  task automatic model_edge(input logic issue, input logic tb, input logic tc,
                            input logic [DW-1:0] data);
    int  n;
    bit  ready_before;
    bit  head_due;
    n = cyc;
    ready_before = (due_q.size() < MAXQ);
    head_due = (due_q.size() > 0) && (due_q[0] <= n);
    e_late = 1'b0;
    e_pre  = 1'b0;
    if (head_due && (n >= burst_s + BL)) begin
      burst_s = n;
      void'(due_q.pop_front());
      head_late_seen = 1'b0;
      e_pre = !((tb == 1'b0) && (tc == 1'b1));
    end else if (head_due && !head_late_seen) begin
      e_late = 1'b1;
      head_late_seen = 1'b1;
    end
    e_ovf = issue && !ready_before;
    if (issue && ready_before) due_q.push_back(n + RL);
    e_cv    = (n >= burst_s) && (n < burst_s + BL);
    e_first = (n == burst_s);
    e_last  = (n == burst_s + BL - 1);
    e_cnt   = due_q.size();
    e_ready = (due_q.size() < MAXQ);
    e_data  = data;
  endtask

  task automatic step(input logic issue, input logic tb, input logic tc,
                      input logic [DW-1:0] data);
    rdIssue = issue;
    dqs_t   = tb;
    dqs_c   = tc;
    inData  = data;
    @(posedge clk2x);
    cyc++;
    model_edge(issue, tb, tc, data);
    @(negedge clk2x);
    check("capValid",    64'(capValid),    64'(e_cv));
    check("burstFirst",  64'(burstFirst),  64'(e_first));
    check("burstLast",   64'(burstLast),   64'(e_last));
    check("lateErr",     64'(lateErr),     64'(e_late));
    check("ovfErr",      64'(ovfErr),      64'(e_ovf));
    check("preambleErr", 64'(preambleErr), 64'(e_pre));
    check("rdReady",     64'(rdReady),     64'(e_ready));
    check("inflightCnt", 64'(inflightCnt), 64'(e_cnt));
    check("capData",     capData,          e_data);
    if (cyc < HN) begin
      h_cv[cyc]    = capValid;
      h_first[cyc] = burstFirst;
      h_last[cyc]  = burstLast;
      h_late[cyc]  = lateErr;
      h_ovf[cyc]   = ovfErr;
      h_pre[cyc]   = preambleErr;
      h_ready[cyc] = rdReady;
    end
    $display("edge %0d issue=%0b cv=%0b first=%0b last=%0b late=%0b ovf=%0b pre=%0b cnt=%0d",
             cyc, issue, capValid, burstFirst, burstLast, lateErr, ovfErr, preambleErr, inflightCnt);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rdIssue = 1'b0;
    dqs_t = 1'b0;
    dqs_c = 1'b1;
    #1;
    check("rst_capValid",    64'(capValid),    64'(0));
    check("rst_burstFirst",  64'(burstFirst),  64'(0));
    check("rst_burstLast",   64'(burstLast),   64'(0));
    check("rst_lateErr",     64'(lateErr),     64'(0));
    check("rst_ovfErr",      64'(ovfErr),      64'(0));
    check("rst_preambleErr", 64'(preambleErr), 64'(0));
    check("rst_capData",     capData,          64'(0));
    check("rst_inflightCnt", 64'(inflightCnt), 64'(0));
    check("rst_rdReady",     64'(rdReady),     64'(1));
    model_clear();
    for (int k = 0; k < HN; k++) begin
      iss[k] = 0; baddq[k] = 0;
      h_cv[k] = 0; h_first[k] = 0; h_last[k] = 0; h_late[k] = 0;
      h_ovf[k] = 0; h_pre[k] = 0; h_ready[k] = 0;
    end
    repeat (3) @(negedge clk2x);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic run_sched(input int ncyc);
    for (int k = 1; k <= ncyc; k++) begin
      if (baddq[k]) step(iss[k], 1'b1, 1'b0, {$urandom, $urandom});
      else          step(iss[k], 1'b0, 1'b1, {$urandom, $urandom});
    end
  endtask

  function automatic int sum_cv(input int a, input int b);
    int s = 0;
    for (int k = a; k <= b; k++) s += int'(h_cv[k]);
    return s;
  endfunction

  function automatic int sum_first(input int a, input int b);
    int s = 0;
    for (int k = a; k <= b; k++) s += int'(h_first[k]);
    return s;
  endfunction

  function automatic int sum_late(input int a, input int b);
    int s = 0;
    for (int k = a; k <= b; k++) s += int'(h_late[k]);
    return s;
  endfunction

  initial begin
    #2;

    // single read: issue at edge 10 -> beats 32..39
    do_reset();
    iss[10] = 1;
    run_sched(60);
    check("single_cv31",    64'(h_cv[31]),    64'(0));
    check("single_cv32",    64'(h_cv[32]),    64'(1));
    check("single_cv40",    64'(h_cv[40]),    64'(0));
    check("single_first32", 64'(h_first[32]), 64'(1));
    check("single_last39",  64'(h_last[39]),  64'(1));
    check("single_beats",   64'(sum_cv(1, 60)),   64'(8));
    check("single_beats_w", 64'(sum_cv(32, 39)),  64'(8));

    // back-to-back: issues at 10 and 18 -> continuous 32..47
    do_reset();
    iss[10] = 1; iss[18] = 1;
    run_sched(70);
    check("b2b_window",  64'(sum_cv(32, 47)),    64'(16));
    check("b2b_total",   64'(sum_cv(1, 70)),     64'(16));
    check("b2b_first32", 64'(h_first[32]),       64'(1));
    check("b2b_first40", 64'(h_first[40]),       64'(1));
    check("b2b_last39",  64'(h_last[39]),        64'(1));
    check("b2b_last47",  64'(h_last[47]),        64'(1));
    check("b2b_nolate",  64'(sum_late(1, 70)),   64'(0));

    // late read: issues at 10 and 14 -> lateErr at 36, second burst 40..47
    do_reset();
    iss[10] = 1; iss[14] = 1;
    run_sched(70);
    check("late_pulse36", 64'(h_late[36]),       64'(1));
    check("late_once",    64'(sum_late(1, 70)),  64'(1));
    check("late_first40", 64'(h_first[40]),      64'(1));
    check("late_last47",  64'(h_last[47]),       64'(1));
    check("late_beats",   64'(sum_cv(1, 70)),    64'(16));

    // overflow: issues at 10..14, fifth is dropped; ovfErr is the pulse
    // registered by the rejecting edge 14, seen before edge 15
    do_reset();
    for (int k = 10; k <= 14; k++) iss[k] = 1;
    run_sched(100);
    check("ovf_ready12", 64'(h_ready[12]),      64'(1));
    check("ovf_ready14", 64'(h_ready[14]),      64'(0));
    check("ovf_pulse",   64'(h_ovf[14]),        64'(1));
    check("ovf_bursts",  64'(sum_first(1, 100)), 64'(4));
    check("ovf_beats",   64'(sum_cv(1, 100)),   64'(32));

    // preamble fault: strobe t=1,c=0 during cycle 31 (sampled at edge 32)
    do_reset();
    iss[10] = 1; baddq[32] = 1;
    run_sched(60);
    check("pre_pulse32", 64'(h_pre[32]),       64'(1));
    check("pre_beats",   64'(sum_cv(1, 60)),   64'(8));

    // reset mid-burst during cycle 35, with a second READ still queued
    do_reset();
    iss[10] = 1; iss[18] = 1;
    run_sched(35);
    check("rstmid_active", 64'(h_cv[35]), 64'(1));
    check("rstmid_queued", 64'(inflightCnt), 64'(1));
    do_reset();
    run_sched(80);
    check("rstmid_noburst", 64'(sum_cv(1, 80)), 64'(0));

    // random traffic against the model
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int k = 1; k <= 300; k++) begin
        logic is, bad;
        is  = ($urandom_range(0, 5) == 0);
        bad = ($urandom_range(0, 9) == 0);
        if (bad) step(is, 1'b1, 1'b0, {$urandom, $urandom});
        else     step(is, 1'b0, 1'b1, {$urandom, $urandom});
      end
      for (int k = 1; k <= 80; k++) step(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phy_read_capture_ctrl.md
PHY_READ_CAPTURE_CTRL -- requirements
Module: phy_read_capture_ctrl

Interface
REQ-001 SHALL have parameter MEM_DATAWIDTH, default 64: DQ bus width.
REQ-002 SHALL have parameter BURST_LENGTH, default 8: beats per READ burst; power of two.
REQ-003 SHALL have parameter READ_LATENCY, default 22: clk2x cycles from READ issue to first captured beat; legal range 2..255.
REQ-004 SHALL have parameter MAX_INFLIGHT, default 4: outstanding READ slots.
REQ-005 SHALL have ports `clk2x in 1` (capture clock) and `rst in 1` (reset, asynchronous, active-low).
REQ-006 SHALL have port `rdIssue in 1`: one-cycle pulse, READ command driven on the DRAM bus.
REQ-007 SHALL have ports `dqs_t in 1` and `dqs_c in 1`: differential read strobe.
REQ-008 SHALL have port `inData in MEM_DATAWIDTH`: raw DQ bus.
REQ-009 SHALL have port `rdReady out 1`: a free slot exists.
REQ-010 SHALL have ports `capValid out 1` and `capData out MEM_DATAWIDTH`: captured beat stream to the read-mode FIFO stage (its inflag/inData).
REQ-011 SHALL have ports `burstFirst out 1` and `burstLast out 1`: first and last beat markers, qualified by capValid.
REQ-012 SHALL have port `inflightCnt out $clog2(MAX_INFLIGHT)+1`: occupied slots.
REQ-013 SHALL have ports `ovfErr out 1`, `lateErr out 1` and `preambleErr out 1`: one-cycle error pulses.

Function
REQ-014 SHALL track outstanding READs in an in-order slot queue; each slot holds a down-counter of width 8.
REQ-015 On rdIssue with rdReady=1, SHALL push a slot loaded so that capValid first rises exactly READ_LATENCY cycles after the edge sampling rdIssue (t -> t+READ_LATENCY).
REQ-016 All occupied slot counters SHALL decrement every cycle and saturate at 0.
REQ-017 SHALL use FSM IDLE -> BURST -> IDLE; a beat counter runs 0..BURST_LENGTH-1.
REQ-018 IDLE -> BURST SHALL occur when the head slot is occupied and its counter has expired; the head SHALL be popped on that transition.
REQ-019 In BURST, capValid SHALL be 1 for exactly BURST_LENGTH consecutive cycles; burstFirst SHALL be high on beat 0 and burstLast on beat BURST_LENGTH-1.
REQ-020 If the next head has expired on beat BURST_LENGTH-1, SHALL stay in BURST with the beat counter reset to 0, giving seamless back-to-back bursts with no gap cycle.
REQ-021 If the head counter expires while in BURST before the last beat, SHALL pulse lateErr once for that slot; the burst SHALL start immediately after the current one (REQ-020 path) and data SHALL NOT be dropped.
REQ-022 capData SHALL be inData registered on every clk2x edge; capData is meaningful only when capValid=1.
REQ-023 On the cycle before each burst start, SHALL sample the preamble: if NOT (dqs_t=0 and dqs_c=1), SHALL pulse preambleErr in the burst's first cycle; the burst proceeds regardless.
REQ-024 SHALL drive rdReady=1 iff inflightCnt<MAX_INFLIGHT; a pop in the same cycle SHALL NOT make a full queue ready.
REQ-025 rdIssue while the queue is full SHALL be dropped and SHALL pulse ovfErr for one cycle; queue and counters SHALL be unchanged.
REQ-026 Simultaneous push and pop SHALL both occur and leave inflightCnt unchanged.
REQ-027 Queue pointers SHALL wrap modulo MAX_INFLIGHT.
REQ-028 inflightCnt SHALL count queued slots only, excluding the burst in progress.

Reset
REQ-029 rst low SHALL asynchronously clear all slots, pointers, the FSM (to IDLE) and the beat counter.
REQ-030 While rst is low, outputs SHALL be capValid=0, burstFirst=0, burstLast=0, all error pulses=0, capData=0, inflightCnt=0 and rdReady=1.
REQ-031 Reset asserted mid-burst SHALL abort the burst with no further capValid; reads in flight SHALL be discarded.

Structure
REQ-032 BURST_LENGTH, READ_LATENCY defaults and the FSM state enum SHALL live in a shared package ddr_phy_pkg.
REQ-033 The slot queue with its per-entry countdown SHALL be a sub-module phy_rd_slot_queue; the FSM and capture register stay in the top.

Verification
REQ-034 Bench SHALL cover single read: rdIssue at cycle 10 -> capValid cycles 32..39, burstFirst@32, burstLast@39, capData = inData of cycles 31..38.
REQ-035 Bench SHALL cover back-to-back reads: rdIssue at 10 and 18 -> capValid continuous 32..47, burstFirst@32,40, burstLast@39,47, lateErr=0.
REQ-036 Bench SHALL cover a late read: rdIssue at 10 and 14 -> lateErr pulse at 36, second burst 40..47.
REQ-037 Bench SHALL cover overflow: 5 issues at 10,11,12,13,14 -> rdReady=0 from 14, ovfErr@15, exactly 4 bursts.
REQ-038 Bench SHALL cover a preamble fault: dqs_t=1, dqs_c=0 at cycle 31 for an issue at 10 -> preambleErr@32, 8 beats still delivered.
REQ-039 Bench SHALL cover reset mid-burst: rst low at 35 -> capValid=0 immediately, inflightCnt=0, no burst after release.
